cordic_vectoring_iter: RTL and testbench
========================================

# cordic_vectoring_iter

Iterative vectoring-mode CORDIC: accepts a signed Cartesian vector (x, y), drives y toward zero over ITER micro-rotations, and returns the scaled magnitude and the angle atan2(y, x). It is the inverse of the rotation-mode shift-accumulate pipeline: that pipeline consumes an angle and produces coordinates; this block consumes coordinates and produces the angle. One shared datapath is reused across iterations, with a valid/ready handshake on both sides.

## Interface
- ITER, 16, number of micro-rotations; legal range 1..30.
- WIDTH, 32, data and angle width; fixed at 32 for this revision.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input vector present.
- in_ready  out  1  block can accept; high only in IDLE.
- x_in  in  32  signed x; legal range [-2^29, 2^29-1].
- y_in  in  32  signed y; same range.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- mag_out  out  32  signed magnitude × K (K ≈ 1.646760258), not gain-corrected.
- ang_out  out  32  signed angle, radians × 2^29 (π = 1686629713).

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready, capture the vector with quadrant pre-rotation, clear the iteration counter i, and go to RUN.
  - If x_in<0: x0=-x_in, y0=-y_in, z0=+π if y_in>=0, else -π.
  - Otherwise: x0=x_in, y0=y_in, z0=0.
- RUN: one micro-rotation per cycle at index i.
  - If y>0 (signed): x+=y>>>i, y-=x>>>i, z+=atan_i.
  - Otherwise: x-=y>>>i, y+=x>>>i, z-=atan_i.
  - Shifts are arithmetic. Both updates use the pre-update x and y.
  - After i=ITER-1, load mag_out=x and ang_out=z, then go to HOLD.
- HOLD: out_valid=1 and in_ready=0. On out_ready, go to IDLE.
- No overlap: a new input is accepted only in IDLE.
- atan ROM: 30 entries, round(atan(2^-i)·2^29).
  - i=0: 421657428; i=1: 248918915; i=2: 131521918.
  - The remaining entries are computed the same way.
- Width rules:
  - All arithmetic is 32-bit two's complement.
  - The input range limit keeps |x|·K·√2 < 2^31, so no overflow occurs.
  - Out-of-range inputs wrap modulo 2^32 and are not flagged.
- Output angle range is approximately (-π-ε, π+ε], where ε ≤ atan(2^-(ITER-1)).
- Zero vector: mag_out=0. ang_out is deterministic (-Σatan_i) and carries no meaning.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - mag_out=0, ang_out=0, internal x/y/z/i=0.

## Timing
- Accept edge: T0.
- Iterations occur on edges T0+1 .. T0+ITER.
- out_valid is high from edge T0+ITER onward; latency is ITER cycles, i.e. 16 by default.
- mag_out and ang_out are stable from T0+ITER until the out_valid&out_ready edge.
- in_ready returns high on the edge after the handshake.
- Best-case throughput is one result per ITER+2 cycles.
- in_valid in RUN or HOLD is ignored; the upstream must hold its data until in_ready.
- rst_n low at any edge, including mid-RUN or in HOLD:
  - The next state is IDLE and all outputs take their reset values.
  - The in-flight result is discarded.
  - rst_n takes priority over handshakes in the same cycle.
- out_ready asserted while in RUN has no effect.

## Test plan
- Latency and magnitude on the x-axis:
  - Stimulus: x=2^28, y=0.
  - Response: out_valid exactly 16 cycles after accept; mag_out≈442048838 (±0.01%); |ang_out| ≤ 20000.
- First quadrant:
  - Stimulus: x=y=2^28.
  - Response: ang_out≈421657428 (±20000); mag_out≈625151000 (±0.01%).
- Left half-plane pre-rotation:
  - Stimulus: x=-2^28, y=0.
  - Response: ang_out≈1686629713 (+π, ±20000); mag_out≈442048838.
- Negative y-axis:
  - Stimulus: x=0, y=-2^28.
  - Response: ang_out≈-843314857 (±20000).
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Response: outputs unchanged, in_ready=0, and in_valid pulses are ignored.
  - Response: after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN:
  - Stimulus: drop rst_n at cycle 7 of an iteration, then release.
  - Response: out_valid=0, mag_out=0, ang_out=0, in_ready=1.
  - Response: the next vector completes normally with a 16-cycle latency.

Source files
------------

// File: rtl/cordic_vectoring_iter_if.sv
// cordic_vectoring_iter_if
// Handshake and data bundle for the iterative vectoring CORDIC.
//   in_valid / in_ready   : input vector handshake (x_in, y_in)
//   out_valid / out_ready : result handshake (mag_out, ang_out)
// slave  : the CORDIC block side
// master : the upstream/downstream user side
interface cordic_vectoring_iter_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] mag_out;
    logic signed [WIDTH-1:0] ang_out;

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, mag_out, ang_out
    );

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, mag_out, ang_out
    );
endinterface

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter
// Iterative vectoring-mode CORDIC. Takes a signed vector (x, y), drives y
// toward zero over ITER micro-rotations on one shared datapath and returns
// the K-scaled magnitude and atan2(y, x) in radians * 2^29.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : cordic_vectoring_iter_if.slave (input and result handshakes)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a vector; captures with pre-rotation
// RUN   | one micro-rotation per cycle, index i = 0 .. ITER-1
// HOLD  | out_valid=1, result held until out_ready
module cordic_vectoring_iter #(
    parameter int ITER  = 16,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cordic_vectoring_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] PI   = 32'sd1686629713;
    localparam logic [4:0]              LAST = 5'(ITER - 1);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic [4:0]              i_q;
    logic signed [WIDTH-1:0] mag_q, ang_q;

    logic signed [WIDTH-1:0] x_cap, y_cap, z_cap;
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_i;
    logic signed [WIDTH-1:0] x_nxt, y_nxt, z_nxt;

    // round(atan(2^-i) * 2^29)
    function automatic logic signed [WIDTH-1:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'sd421657428;
            5'd1:    atan_rom = 32'sd248918915;
            5'd2:    atan_rom = 32'sd131521918;
            5'd3:    atan_rom = 32'sd66762579;
            5'd4:    atan_rom = 32'sd33510843;
            5'd5:    atan_rom = 32'sd16771758;
            5'd6:    atan_rom = 32'sd8387925;
            5'd7:    atan_rom = 32'sd4194219;
            5'd8:    atan_rom = 32'sd2097141;
            5'd9:    atan_rom = 32'sd1048575;
            5'd10:   atan_rom = 32'sd524288;
            5'd11:   atan_rom = 32'sd262144;
            5'd12:   atan_rom = 32'sd131072;
            5'd13:   atan_rom = 32'sd65536;
            5'd14:   atan_rom = 32'sd32768;
            5'd15:   atan_rom = 32'sd16384;
            5'd16:   atan_rom = 32'sd8192;
            5'd17:   atan_rom = 32'sd4096;
            5'd18:   atan_rom = 32'sd2048;
            5'd19:   atan_rom = 32'sd1024;
            5'd20:   atan_rom = 32'sd512;
            5'd21:   atan_rom = 32'sd256;
            5'd22:   atan_rom = 32'sd128;
            5'd23:   atan_rom = 32'sd64;
            5'd24:   atan_rom = 32'sd32;
            5'd25:   atan_rom = 32'sd16;
            5'd26:   atan_rom = 32'sd8;
            5'd27:   atan_rom = 32'sd4;
            5'd28:   atan_rom = 32'sd2;
            5'd29:   atan_rom = 32'sd1;
            default: atan_rom = 32'sd0;
        endcase
    endfunction

    // Left half-plane vectors are rotated by pi so the iterations only
    // ever have to cover (-pi/2, pi/2).
    always_comb begin
        x_cap = bus.x_in;
        y_cap = bus.y_in;
        z_cap = '0;
        if (bus.x_in[WIDTH-1]) begin
            x_cap = -bus.x_in;
            y_cap = -bus.y_in;
            z_cap = bus.y_in[WIDTH-1] ? -PI : PI;
        end
    end

    // One micro-rotation; both updates use the pre-update x and y.
    always_comb begin
        atan_i = atan_rom(i_q);
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        if (y_q > 0) begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_i;
        end else begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (i_q == LAST)   state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            i_q   <= '0;
            mag_q <= '0;
            ang_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q <= x_cap;
                        y_q <= y_cap;
                        z_q <= z_cap;
                        i_q <= '0;
                    end
                end
                RUN: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    i_q <= i_q + 5'd1;
                    if (i_q == LAST) begin
                        mag_q <= x_nxt;
                        ang_q <= z_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mag_out = mag_q;
    assign bus.ang_out = ang_q;
endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// tb_cordic_vectoring_iter
// Directed bench for cordic_vectoring_iter. A behavioural model computes the
// exact result from the capture/rotation rules using an atan table derived
// from $atan; a compare process checks every cycle a result is presented.
// Literal expectations and ideal-math tolerances pin the model.
module tb_cordic_vectoring_iter;
    localparam int    ITER = 16;
    localparam int    PI   = 1686629713;
    localparam real   KGAIN = 1.646760258;
    localparam real   SCALE = 536870912.0;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   pending;
    int   exp_mag;
    int   exp_ang;
    int   atan_tab[ITER];

    cordic_vectoring_iter_if bus();

    cordic_vectoring_iter #(.ITER(ITER), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input real ideal, input real tol);
        real d;
        total++;
        d = real'(act) - ideal;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0f within %0f", name, act, ideal, tol);
        end
    endtask

    // Result from the vectoring rules with plain integer arithmetic.
    task automatic model(input int xi, input int yi, output int m, output int a);
        int x, y, z, xs, ys;
        if (xi < 0) begin
            x = -xi;
            y = -yi;
            z = (yi >= 0) ? PI : -PI;
        end else begin
            x = xi;
            y = yi;
            z = 0;
        end
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (y > 0) begin
                x = x + ys;
                y = y - xs;
                z = z + atan_tab[i];
            end else begin
                x = x - ys;
                y = y + xs;
                z = z - atan_tab[i];
            end
        end
        m = x;
        a = z;
    endtask

    // Result presented while a result is expected must equal the model;
    // any result presented otherwise is spurious.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (pending) begin
                check("mag_out", bus.mag_out, exp_mag);
                check("ang_out", bus.ang_out, exp_ang);
                check("in_ready_while_valid", bus.in_ready, 0);
            end else begin
                check("spurious_out_valid", bus.out_valid, 0);
            end
        end
    end

    int last_mag, last_ang;

    task automatic do_vector(input int xv, input int yv, input int hold);
        int cyc, m, a;
        model(xv, yv, m, a);
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.x_in     = xv;
        bus.y_in     = yv;
        exp_mag      = m;
        exp_ang      = a;
        pending      = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x_in     = 0;
        bus.y_in     = 0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid !== 1'b1)
                check("in_ready_run", bus.in_ready, 0);
        end
        check("latency", cyc, ITER);
        last_mag = bus.mag_out;
        last_ang = bus.ang_out;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.x_in     = 12345 + h;
            bus.y_in     = -777 * h;
            @(posedge clk);
            #1;
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_mag_stable", bus.mag_out, last_mag);
            check("hold_ang_stable", bus.ang_out, last_ang);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        pending       = 1'b0;
        check("release_out_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
    endtask

    task automatic ideal_check(input int xv, input int yv);
        real xr, yr;
        xr = real'(xv);
        yr = real'(yv);
        check_tol("ideal_mag", last_mag, KGAIN * $sqrt(xr * xr + yr * yr),
                  KGAIN * $sqrt(xr * xr + yr * yr) * 1.0e-4 + 16.0);
        check_tol("ideal_ang", last_ang, $atan2(yr, xr) * SCALE, 20000.0);
    endtask

    typedef struct {
        int x;
        int y;
    } vec_t;

    vec_t extra[4];

    initial begin
        total = 0;
        bad   = 0;
        pending = 1'b0;
        exp_mag = 0;
        exp_ang = 0;
        last_mag = 0;
        last_ang = 0;
        for (int i = 0; i < ITER; i++)
            atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * SCALE + 0.5);
        check("atan_tab0", atan_tab[0], 421657428);
        check("atan_tab1", atan_tab[1], 248918915);
        check("atan_tab2", atan_tab[2], 131521918);

        extra[0] = '{x: -268435456, y: -134217728};
        extra[1] = '{x: 123456789,  y: -98765432};
        extra[2] = '{x: -300000000, y: 200000000};
        extra[3] = '{x: 536870911,  y: 1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = 0;
        bus.y_in      = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_mag", bus.mag_out, 0);
        check("rst_ang", bus.ang_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // x-axis
        do_vector(268435456, 0, 0);
        check_tol("xaxis_mag", last_mag, 442048838.0, 44205.0);
        check_tol("xaxis_ang", last_ang, 0.0, 20000.0);

        // first quadrant diagonal
        do_vector(268435456, 268435456, 0);
        check_tol("q1_ang", last_ang, 421657428.0, 20000.0);
        check_tol("q1_mag", last_mag, 625151000.0, 62515.0);

        // left half-plane, with backpressure and ignored in_valid pulses
        do_vector(-268435456, 0, 5);
        check_tol("lhp_ang", last_ang, 1686629713.0, 20000.0);
        check_tol("lhp_mag", last_mag, 442048838.0, 44205.0);

        // negative y-axis
        do_vector(0, -268435456, 0);
        check_tol("negy_ang", last_ang, -843314857.0, 20000.0);

        for (int k = 0; k < 4; k++) begin
            do_vector(extra[k].x, extra[k].y, k % 2);
            ideal_check(extra[k].x, extra[k].y);
        end

        // zero vector: magnitude zero, angle is minus the table sum
        do_vector(0, 0, 0);
        check("zero_mag", last_mag, 0);
        begin
            int s;
            s = 0;
            for (int i = 0; i < ITER; i++) s = s - atan_tab[i];
            check("zero_ang", last_ang, s);
        end

        // reset in the middle of an iteration run
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_in     = 200000000;
        bus.y_in     = 100000000;
        pending      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_mag", bus.mag_out, 0);
        check("midrst_ang", bus.ang_out, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("midrst_no_result", bus.out_valid, 0);
        end
        do_vector(268435456, 268435456, 0);
        ideal_check(268435456, 268435456);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
